// File: rtl/my_de0_nano.sv
// DE0-Nano top level: 16-bit single-cycle load/store core with program ROM,
// 8K x 16 data RAM, and bus visibility on the GPIO headers.
module my_de0_nano #(
    parameter string IMEM_FILE  = "memfile.dat",
    parameter int    IMEM_DEPTH = 256,
    // Word image of IMEM_FILE, supplied pre-converted so the ROM is a pure constant
    parameter logic [IMEM_DEPTH-1:0][15:0] IMEM_INIT = {
        {(IMEM_DEPTH-6){16'h0000}},
        16'h5005, 16'h3440, 16'h0490, 16'h0490, 16'h1099, 16'h1042
    }
) (
    input  logic        CLOCK_50,
    input  logic [33:0] GPIO_0_PI,
    output logic [33:0] GPIO_1,
    output logic [12:0] GPIO_2
);
    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [IMEM_DEPTH-1:0][15:0] DEFAULT_IMAGE = {
        {(IMEM_DEPTH-6){16'h0000}},
        16'h5005, 16'h3440, 16'h0490, 16'h0490, 16'h1099, 16'h1042
    };
    localparam logic [IMEM_DEPTH-1:0][15:0] ROM_IMAGE =
        (IMEM_FILE == "") ? DEFAULT_IMAGE : IMEM_INIT;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;

    logic        rst;
    logic        unused_pins;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [2:0]  funct;
    logic [15:0] imm;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] alu_res;
    logic [15:0] ram_rd;
    logic [15:0] wb_data;
    logic [2:0]  reg_waddr;
    logic        reg_we;
    logic        mem_write;

    logic [15:0] regs [8];
    logic [15:0] ram  [8192];

    assign rst         = GPIO_0_PI[1];
    assign unused_pins = ^{GPIO_0_PI[33:2], GPIO_0_PI[0]};

    assign instr = ROM_IMAGE[pc[AW-1:0]];
    assign op    = instr[15:12];
    assign rs    = instr[11:9];
    assign rt    = instr[8:6];
    assign rd    = instr[5:3];
    assign funct = instr[2:0];
    assign imm   = {{10{instr[5]}}, instr[5:0]};

    // r0 is hardwired to zero on read; writes to it are dropped below
    assign rs_val = (rs == 3'd0) ? 16'd0 : regs[rs];
    assign rt_val = (rt == 3'd0) ? 16'd0 : regs[rt];
    assign ram_rd = ram[alu_res[12:0]];

    always_comb begin
        alu_res   = rs_val + imm;
        reg_we    = 1'b0;
        reg_waddr = rt;
        mem_write = 1'b0;
        pc_next   = pc + 16'd1;
        case (op)
            OP_RTYPE: begin
                reg_we    = 1'b1;
                reg_waddr = rd;
                case (funct)
                    3'd0:    alu_res = rs_val + rt_val;
                    3'd1:    alu_res = rs_val - rt_val;
                    3'd2:    alu_res = rs_val & rt_val;
                    3'd3:    alu_res = rs_val | rt_val;
                    3'd4:    alu_res = {15'd0, $signed(rs_val) < $signed(rt_val)};
                    default: reg_we  = 1'b0;
                endcase
            end
            OP_ADDI: reg_we = 1'b1;
            OP_LW:   reg_we = 1'b1;
            // A store in a reset cycle must not reach the RAM
            OP_SW:   mem_write = ~rst;
            OP_BEQ: begin
                alu_res = rs_val - rt_val;
                if (rs_val == rt_val) pc_next = pc + 16'd1 + imm;
            end
            OP_J:    pc_next = {pc[15:12], instr[11:0]};
            default: ;
        endcase
    end

    assign wb_data = (op == OP_LW) ? ram_rd : alu_res;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            pc <= 16'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else begin
            pc <= pc_next;
            if (reg_we && reg_waddr != 3'd0) regs[reg_waddr] <= wb_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_write) ram[alu_res[12:0]] <= rt_val;
    end

    assign GPIO_1 = {mem_write, 1'b0, pc, rt_val};
    assign GPIO_2 = alu_res[12:0];
endmodule

// File: tb/tb_my_de0_nano.sv
// Directed bench: default program on one instance, ALU/LW/BEQ/J/wrap/reset
// program on a second instance sharing the clock.
module tb_my_de0_nano;
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic [33:0] pi0;
    logic [33:0] pi1;
    logic [33:0] g1_a;
    logic [33:0] g1_b;
    logic [12:0] g2_a;
    logic [12:0] g2_b;
    int checks = 0;
    int errors = 0;
    logic [15:0] pc1_exp [32];

    function automatic logic [255:0][15:0] prog1();
        logic [255:0][15:0] p;
        p = '0;
        p[0]  = 16'h214C; // LW   r5,12(r0)
        p[1]  = 16'h314D; // SW   r5,13(r0)
        p[2]  = 16'h1042; // ADDI r1,r0,2
        p[3]  = 16'h10BD; // ADDI r2,r0,-3
        p[4]  = 16'h0299; // SUB  r3,r1,r2
        p[5]  = 16'h30CC; // SW   r3,12(r0)
        p[6]  = 16'h30C8; // SW   r3,8(r0)
        p[7]  = 16'h029A; // AND  r3,r1,r2
        p[8]  = 16'h30C8;
        p[9]  = 16'h029B; // OR   r3,r1,r2
        p[10] = 16'h30C8;
        p[11] = 16'h045C; // SLT  r3,r2,r1
        p[12] = 16'h30C8;
        p[13] = 16'h2108; // LW   r4,8(r0)
        p[14] = 16'h3109; // SW   r4,9(r0)
        p[15] = 16'h1205; // ADDI r0,r1,5
        p[16] = 16'h300A; // SW   r0,10(r0)
        p[17] = 16'h4285; // BEQ  r1,r2,+5 (not taken)
        p[18] = 16'h4702; // BEQ  r3,r4,+2 (taken)
        p[19] = 16'h3040;
        p[20] = 16'h3040;
        p[21] = 16'h304C; // SW   r1,12(r0)
        p[22] = 16'h4020; // BEQ  r0,r0,-32 -> 0xFFF7
        p[8'hF7] = 16'h5FFE; // J 0xFFE
        p[8'hFE] = 16'h6000; // NOP
        p[8'hFF] = 16'hF000; // NOP, PC wraps to 0
        return p;
    endfunction

    localparam logic [255:0][15:0] PROG1 = prog1();

    my_de0_nano dut0 (.CLOCK_50(clk), .GPIO_0_PI(pi0), .GPIO_1(g1_a), .GPIO_2(g2_a));
    my_de0_nano #(.IMEM_INIT(PROG1)) dut1 (
        .CLOCK_50(clk), .GPIO_0_PI(pi1), .GPIO_1(g1_b), .GPIO_2(g2_b));

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_store(input string tag, input logic [33:0] g1, input logic [12:0] g2,
                             input logic [12:0] adr, input logic [15:0] data);
        chk({tag, "_mw"}, g1[33], 1'b1);
        chk({tag, "_adr"}, g2, adr);
        chk({tag, "_data"}, g1[15:0], data);
    endtask

    initial begin
        pc1_exp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7,
                    16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15,
                    16'd16, 16'd17, 16'd18, 16'd21, 16'd22, 16'hFFF7, 16'hFFFE, 16'hFFFF,
                    16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
        pi0 = 34'h3_FFFF_FFFF;
        pi1 = 34'h0_0000_0002;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc0", g1_a[31:16], 16'd0);
        chk("rst_mw0", g1_a[33], 1'b0);
        chk("rst_bit32", g1_a[32], 1'b0);
        chk("rst_pc1", g1_b[31:16], 16'd0);
        #7;
        pi0 = 34'h3_FFFF_FFFD; // reset low, every other pin high
        pi1 = 34'h0;

        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            chk($sformatf("d0_pc_%0d", n), g1_a[31:16], (n < 5) ? n : 5);
            if (n == 4) chk_store("d0_store", g1_a, g2_a, 13'd100, 16'd2);
            else chk($sformatf("d0_mw_%0d", n), g1_a[33], 1'b0);
            chk($sformatf("d1_pc_%0d", n), g1_b[31:16], pc1_exp[n]);
            case (n)
                1: begin
                    chk("d1_sw13_mw", g1_b[33], 1'b1);
                    chk("d1_sw13_adr", g2_b, 13'd13);
                end
                5:  chk_store("d1_sub12", g1_b, g2_b, 13'd12, 16'h0005);
                6:  chk_store("d1_sub", g1_b, g2_b, 13'd8, 16'h0005);
                8:  chk_store("d1_and", g1_b, g2_b, 13'd8, 16'h0000);
                10: chk_store("d1_or", g1_b, g2_b, 13'd8, 16'hFFFF);
                12: chk_store("d1_slt", g1_b, g2_b, 13'd8, 16'h0001);
                13: begin
                    chk("d1_lw_mw", g1_b[33], 1'b0);
                    chk("d1_lw_adr", g2_b, 13'd8);
                end
                14: chk_store("d1_lw_data", g1_b, g2_b, 13'd9, 16'h0001);
                15: begin
                    chk("d1_addi_r0_mw", g1_b[33], 1'b0);
                    chk("d1_addi_r0_adr", g2_b, 13'd7);
                end
                16: chk_store("d1_r0", g1_b, g2_b, 13'd10, 16'h0000);
                19: chk_store("d1_beq_taken", g1_b, g2_b, 13'd12, 16'h0002);
                25: chk_store("d1_lw12", g1_b, g2_b, 13'd13, 16'h0002);
                29: begin
                    chk_store("d1_pre_rst", g1_b, g2_b, 13'd12, 16'h0005);
                    pi1 = 34'h0_0000_0002;
                    #1;
                    chk("d1_rst_mw", g1_b[33], 1'b0);
                end
                30: pi1 = 34'h0;
                31: chk_store("d1_rst_suppressed", g1_b, g2_b, 13'd13, 16'h0002);
                default: ;
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
